scan_job_scheduler: RTL and testbench
=====================================

Name: scan_job_scheduler

Overview:
Sequences database scans on the HBM read/norm engine. It accepts scan jobs (byte range, d_model, norm mode, tag) into a small queue and splits each job into CHUNK_BYTES-sized engine runs. For each run it pulses start with a start/end address, waits for done, and reports one completion per job. It sits between the host/command layer and the HBM read engine, and drives the engine's start, start_addr, end_addr, d_model and get_norm inputs.

Parameters:
ADDR_W, 32, byte address width
LEN_W, 32, job length width in bytes
TAG_W, 8, job tag width
CHUNK_BYTES, 1048576, bytes per engine run; power of 2
JOB_DEPTH, 4, job queue depth; power of 2, >=2
CNT_W, 16, completed-chunk counter width
WDOG_CYCLES, 1048576, watchdog limit (used only with SCAN_WDOG_EN)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
job_valid  in  1  job offer
job_ready  out  1  queue not full
job_base_addr  in  ADDR_W  first byte of the scan
job_len_bytes  in  LEN_W  scan length in bytes
job_d_model  in  11  vector dimension
job_get_norm  in  1  norm mode
job_tag  in  TAG_W  returned with the completion
eng_start  out  1  one-cycle engine start pulse
eng_start_addr  out  ADDR_W  chunk first byte
eng_end_addr  out  ADDR_W  chunk last byte (inclusive)
eng_d_model  out  11  d_model of the current job
eng_get_norm  out  1  get_norm of the current job
eng_done  in  1  engine done pulse
eng_abort  out  1  abort pulse (watchdog)
cmp_valid  out  1  one-cycle completion pulse
cmp_tag  out  TAG_W  completed job tag
cmp_status  out  2  00 OK, 01 ERR_CFG, 10 ERR_RANGE, 11 TIMEOUT
cmp_chunks  out  CNT_W  engine runs completed for the job
busy  out  1  state != IDLE or queue not empty

Behaviour:
- Reset: all registered outputs are 0, the queue is empty, the state is IDLE, and job_ready=1. Reset mid-job clears immediately and drops all jobs with no completion; the engine shares nrst.
- Queue: a push happens when job_valid && job_ready. job_ready = !full (combinational from the count). There is no bypass. Jobs complete strictly in acceptance order.
- IDLE: if the queue is not empty, pop into the working registers and go to CHECK.
- CHECK, evaluated in this priority order:
  - d_model not in {128, 256, 384, 512, 768, 1024}: status 01, go to COMPLETE.
  - Else if base + len > 2^ADDR_W (computed at ADDR_W+1 bits): status 10, go to COMPLETE.
  - Else if len == 0: status 00, chunks 0, go to COMPLETE.
  - Else: cur_addr = base, remaining = len, chunk_cnt = 0, go to ISSUE.
- ISSUE: eng_start=1 for this cycle only.
  - eng_start_addr = cur_addr.
  - eng_end_addr = cur_addr + min(remaining, CHUNK_BYTES) - 1.
  - Go to WAIT.
  - The address, d_model and get_norm outputs stay stable from ISSUE until the next ISSUE or IDLE.
- WAIT: on eng_done:
  - chunk_cnt += 1, cur_addr += run size, remaining -= run size.
  - If remaining == 0, status 00 and go to COMPLETE; else go to ISSUE.
  - eng_done in any other state is ignored. The minimum WAIT is 1 cycle.
- COMPLETE: cmp_valid=1 for one cycle with cmp_tag, cmp_status and cmp_chunks, then go to IDLE.
- cmp_chunks saturates at 2^CNT_W-1.
- Latency:
  - Job accepted at edge t: CHECK at t+1, eng_start high in the cycle after edge t+2.
  - eng_done to the next eng_start: 1 cycle.
  - Last eng_done to cmp_valid: 1 cycle.
- Only full chunks, plus one trailing partial chunk, are issued. No chunk crosses past base+len-1.

Optional Feature:
SCAN_WDOG_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches WDOG_CYCLES without eng_done: eng_abort=1 for one cycle, status 11, cmp_chunks = chunks completed so far, go to COMPLETE. The remaining chunks are skipped.
  - eng_done arriving in the same cycle as expiry wins (normal path).
- Undefined: eng_abort is tied 0 and WAIT is unbounded.

Test Plan:
1. CHUNK_BYTES=0x100000, job base 0x1000, len 0x300000, d_model 512, tag 0x5A -> three eng_start pulses, ranges 0x1000-0x100FFF, 0x101000-0x200FFF, 0x201000-0x300FFF; cmp_valid with tag 0x5A, status 00, chunks 3; eng_d_model=512 throughout.
2. Partial chunk: base 0, len 0x180000 -> two runs, second range 0x100000-0x17FFFF; status 00, chunks 2.
3. Errors and zero length:
   - d_model 300 -> no eng_start; status 01, chunks 0, 2 cycles after acceptance.
   - len 0, d_model 128 -> status 00, chunks 0.
   - base 0xFFF00000, len 0x200000 -> status 10.
4. Back-pressure with eng_done withheld, 6 jobs offered back-to-back -> 5 accepted (1 active, 4 queued), job_ready=0 on the 6th. After releasing eng_done, completions arrive in tag order 0..4 and the 6th is then accepted.
5. Reset mid-WAIT with 2 jobs queued -> eng_start=0, busy=0, job_ready=1, and no cmp_valid after nrst releases.
6. SCAN_WDOG_EN, WDOG_CYCLES=16, 3-chunk job, first eng_done then withheld -> eng_abort pulses on the 16th WAIT cycle of run 2; status 11, chunks 1. The next queued job proceeds normally.

Source files
------------

// File: rtl/scan_job_scheduler.sv
// scan_job_scheduler: queues scan jobs and splits each into CHUNK_BYTES engine runs; watchdog enabled by SCAN_WDOG_EN
module scan_job_scheduler #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 32,
  parameter int TAG_W       = 8,
  parameter int CHUNK_BYTES = 1048576,
  parameter int JOB_DEPTH   = 4,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_base_addr,
  input  logic [LEN_W-1:0]  job_len_bytes,
  input  logic [10:0]       job_d_model,
  input  logic              job_get_norm,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_start_addr,
  output logic [ADDR_W-1:0] eng_end_addr,
  output logic [10:0]       eng_d_model,
  output logic              eng_get_norm,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic              cmp_valid,
  output logic [TAG_W-1:0]  cmp_tag,
  output logic [1:0]        cmp_status,
  output logic [CNT_W-1:0]  cmp_chunks,
  output logic              busy
);
  localparam int PW = $clog2(JOB_DEPTH);
  localparam int QW = ADDR_W + LEN_W + 11 + 1 + TAG_W;
  localparam logic [LEN_W-1:0] CHUNK_L = LEN_W'(CHUNK_BYTES);
  localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, COMPLETE} state_t;
  state_t state, next_state;
  logic [QW-1:0] q_mem [JOB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] q_cnt;
  logic push, pop;
  logic [ADDR_W-1:0] base_r, cur_addr, addr_next;
  logic [LEN_W-1:0] len_r, remaining, cur_run, rem_next;
  logic [10:0] dm_r;
  logic gn_r;
  logic [TAG_W-1:0] tag_r;
  logic [CNT_W-1:0] chunk_cnt;
  logic [1:0] status_r;
  logic dm_ok, range_err, wd_expire;

  function automatic logic [LEN_W-1:0] run_of(input logic [LEN_W-1:0] rem);
    return rem < CHUNK_L ? rem : CHUNK_L;
  endfunction

  function automatic logic [ADDR_W-1:0] end_of(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] rem);
    return a + ADDR_W'(run_of(rem)) - ADDR_W'(1);
  endfunction

  assign job_ready = q_cnt != (PW+1)'(JOB_DEPTH);
  assign push = job_valid && job_ready;
  assign pop = state == IDLE && q_cnt != '0;
  assign busy = state != IDLE || q_cnt != '0;
  assign cur_run = run_of(remaining);
  assign rem_next = remaining - cur_run;
  assign addr_next = cur_addr + ADDR_W'(cur_run);
  assign dm_ok = dm_r inside {11'd128, 11'd256, 11'd384, 11'd512, 11'd768, 11'd1024};
  assign range_err = ({1'b0, base_r} + (ADDR_W+1)'(len_r)) > ADDR_SPAN;
  assign cmp_tag = tag_r;
  assign cmp_status = status_r;
  assign cmp_chunks = chunk_cnt;

`ifdef SCAN_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  assign wd_expire = state == WAIT && !eng_done && wd_cnt == WW'(WDOG_CYCLES - 1);
  // WAIT-cycle counter, restarted on every issue
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) wd_cnt <= '0;
    else if (state == ISSUE) wd_cnt <= '0;
    else if (state == WAIT) wd_cnt <= wd_cnt + WW'(1);
`else
  assign wd_expire = WDOG_CYCLES < 0;
`endif

  // job queue storage, written on accepted offers
  always_ff @(posedge clk)
    if (push) q_mem[wr_ptr] <= {job_base_addr, job_len_bytes, job_d_model, job_get_norm, job_tag};

  // queue pointers and occupancy
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      q_cnt <= q_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end

  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= next_state;

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = pop ? CHECK : IDLE;
      CHECK:    next_state = (!dm_ok || range_err || len_r == '0) ? COMPLETE : ISSUE;
      ISSUE:    next_state = WAIT;
      WAIT:     next_state = eng_done ? (rem_next == '0 ? COMPLETE : ISSUE) : wd_expire ? COMPLETE : WAIT;
      COMPLETE: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // state-decoded pulses
  always_comb begin
    eng_start = state == ISSUE;
    cmp_valid = state == COMPLETE;
    eng_abort = wd_expire;
  end

  // working registers, run bookkeeping and held engine command
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      {base_r, len_r, dm_r, gn_r, tag_r} <= '0;
      cur_addr <= '0;
      remaining <= '0;
      chunk_cnt <= '0;
      status_r <= '0;
      eng_start_addr <= '0;
      eng_end_addr <= '0;
      eng_d_model <= '0;
      eng_get_norm <= 1'b0;
    end else begin
      if (pop) {base_r, len_r, dm_r, gn_r, tag_r} <= q_mem[rd_ptr];
      if (state == CHECK) begin
        status_r <= !dm_ok ? 2'b01 : range_err ? 2'b10 : 2'b00;
        chunk_cnt <= '0;
        cur_addr <= base_r;
        remaining <= len_r;
        if (next_state == ISSUE) begin
          eng_start_addr <= base_r;
          eng_end_addr <= end_of(base_r, len_r);
          eng_d_model <= dm_r;
          eng_get_norm <= gn_r;
        end
      end
      if (state == WAIT && eng_done) begin
        chunk_cnt <= &chunk_cnt ? chunk_cnt : chunk_cnt + CNT_W'(1);
        cur_addr <= addr_next;
        remaining <= rem_next;
        if (rem_next != '0) begin
          eng_start_addr <= addr_next;
          eng_end_addr <= end_of(addr_next, rem_next);
        end
      end else if (wd_expire) status_r <= 2'b11;
    end
endmodule

// File: tb/tb_scan_job_scheduler.sv
// tb_scan_job_scheduler: random and directed jobs checked against a chunk-list reference model
module tb_scan_job_scheduler;
  localparam longint CHUNK = 'h100000;
  logic clk = 0, nrst = 0;
  logic job_valid = 0, job_ready, job_get_norm = 0;
  logic [31:0] job_base_addr = 0, job_len_bytes = 0;
  logic [10:0] job_d_model = 0;
  logic [7:0] job_tag = 0;
  logic eng_start, eng_get_norm, eng_done, eng_abort, cmp_valid, busy;
  logic [31:0] eng_start_addr, eng_end_addr;
  logic [10:0] eng_d_model;
  logic [7:0] cmp_tag;
  logic [1:0] cmp_status;
  logic [15:0] cmp_chunks;

  scan_job_scheduler #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .nrst(nrst), .job_valid(job_valid), .job_ready(job_ready),
    .job_base_addr(job_base_addr), .job_len_bytes(job_len_bytes), .job_d_model(job_d_model),
    .job_get_norm(job_get_norm), .job_tag(job_tag), .eng_start(eng_start),
    .eng_start_addr(eng_start_addr), .eng_end_addr(eng_end_addr), .eng_d_model(eng_d_model),
    .eng_get_norm(eng_get_norm), .eng_done(eng_done), .eng_abort(eng_abort),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_status(cmp_status),
    .cmp_chunks(cmp_chunks), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint base, len, acc;
    int dm, tag, wd_after;
    bit gn, lat;
  } job_t;

  int n_chk = 0, n_pass = 0;
  longint cyc = 0, last_start = 0;
  job_t q[$];
  job_t j;
  int runs = 0, max_r, nxt_wd = -1;
  bit nxt_lat = 0, eng_hold = 0;
  int eng_runs = 0, hold_run = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int exp_status(job_t x);
    if (!(x.dm inside {128, 256, 384, 512, 768, 1024})) return 1;
    if (x.base + x.len > 64'h1_0000_0000) return 2;
    return 0;
  endfunction

  function automatic int exp_chunks(job_t x);
    return exp_status(x) != 0 ? 0 : int'((x.len + CHUNK - 1) / CHUNK);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // engine model: done 1..4 cycles after start, held on request, dropped on abort or reset
  initial begin
    int d;
    bit stop;
    eng_done = 0;
    forever begin
      @(negedge clk);
      eng_done = 0;
      if (eng_start && nrst) begin
        eng_runs++;
        d = $urandom_range(1, 4);
        stop = 0;
        while (!stop && (d > 0 || eng_hold || eng_runs == hold_run)) begin
          @(negedge clk);
          d--;
          if (eng_abort || !nrst) stop = 1;
        end
        if (!stop) eng_done = 1;
      end
    end
  end

  // monitor and reference model
  always @(negedge clk) begin
    if (!nrst) begin
      q.delete();
      runs = 0;
    end else begin
      if (eng_start) begin
        if (q.size() == 0) check("start_without_job", 1, 0);
        else begin
          j = q[0];
          max_r = j.wd_after >= 0 ? j.wd_after + 1 : exp_chunks(j);
          if (runs >= max_r) check("extra_start", runs, max_r - 1);
          else begin
            check("start_addr", eng_start_addr, j.base + runs * CHUNK);
            check("end_addr", eng_end_addr,
                  (j.base + j.len < j.base + (runs + 1) * CHUNK ? j.base + j.len : j.base + (runs + 1) * CHUNK) - 1);
            check("d_model", eng_d_model, j.dm);
            check("get_norm", eng_get_norm, j.gn);
            if (j.lat && runs == 0) check("start_latency", cyc - j.acc, 3);
          end
          runs++;
          last_start = cyc;
        end
      end
      if (eng_abort) begin
        if (q.size() == 0 || q[0].wd_after < 0) check("unexpected_abort", 1, 0);
        else begin
          check("abort_wait_cycles", cyc - last_start, 16);
          check("abort_run", runs, q[0].wd_after + 1);
        end
      end
      if (cmp_valid) begin
        if (q.size() == 0) check("spurious_cmp", 1, 0);
        else begin
          j = q.pop_front();
          check("cmp_tag", cmp_tag, j.tag);
          check("cmp_status", cmp_status, j.wd_after >= 0 ? 3 : exp_status(j));
          check("cmp_chunks", cmp_chunks, j.wd_after >= 0 ? j.wd_after : exp_chunks(j));
          check("runs_issued", runs, j.wd_after >= 0 ? j.wd_after + 1 : exp_chunks(j));
          if (j.lat && exp_chunks(j) == 0) check("cmp_latency", cyc - j.acc, 3);
        end
        runs = 0;
      end
      if (job_valid && job_ready)
        q.push_back('{base: job_base_addr, len: job_len_bytes, acc: cyc, dm: job_d_model,
                      tag: job_tag, wd_after: nxt_wd, gn: job_get_norm, lat: nxt_lat});
    end
  end

  task automatic drive(input logic [31:0] b, input logic [31:0] l, input int dm, input bit gn, input int tag);
    job_base_addr = b;
    job_len_bytes = l;
    job_d_model = 11'(dm);
    job_get_norm = gn;
    job_tag = 8'(tag);
    job_valid = 1;
  endtask

  task automatic submit(input logic [31:0] b, input logic [31:0] l, input int dm, input bit gn,
                        input int tag, input int wd, input bit lat);
    bit acc = 0;
    int t = 0;
    @(posedge clk); #1;
    nxt_wd = wd;
    nxt_lat = lat;
    drive(b, l, dm, gn, tag);
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = job_ready;
      @(posedge clk); #1;
      t++;
    end
    job_valid = 0;
    if (!acc) check("submit_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int dms[6] = '{128, 256, 384, 512, 768, 1024};
    bit acc;
    int t;
    logic [31:0] b, l;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", eng_start, 0);
    check("rst_cmp", cmp_valid, 0);
    check("rst_abort", eng_abort, 0);
    check("rst_end_addr", eng_end_addr, 0);
    check("rst_chunks", cmp_chunks, 0);
    nrst = 1;
    submit(32'h1000, 32'h300000, 512, 1, 'h5A, -1, 1);
    wait_idle();
    submit(32'h0, 32'h180000, 256, 0, 1, -1, 1);
    wait_idle();
    submit(32'h20, 32'h100, 300, 0, 2, -1, 1);
    wait_idle();
    submit(32'h40, 32'h0, 128, 1, 3, -1, 1);
    wait_idle();
    submit(32'hFFF00000, 32'h200000, 384, 0, 4, -1, 1);
    wait_idle();
    submit(32'hFFF00000, 32'h100000, 768, 1, 5, -1, 1);
    wait_idle();
    submit(32'h7, 32'h100000, 1024, 0, 6, -1, 1);
    wait_idle();
    submit(32'h123, 32'h1, 128, 1, 7, -1, 1);
    wait_idle();
    eng_hold = 1;
    nxt_wd = -1;
    nxt_lat = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      drive(32'(i) * 32'h1000, 32'h800, 256, 0, i);
      @(negedge clk);
      check($sformatf("bp_ready%0d", i), job_ready, i < 5);
      @(posedge clk); #1;
    end
    repeat (5) @(negedge clk);
    check("bp_full", job_ready, 0);
    check("bp_busy", busy, 1);
    eng_hold = 0;
    acc = 0;
    t = 0;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = job_ready;
      t++;
    end
    check("bp_sixth_accepted", acc, 1);
    @(posedge clk); #1;
    job_valid = 0;
    wait_idle();
    eng_hold = 1;
    submit(32'h0, 32'h200000, 512, 0, 'h10, -1, 0);
    submit(32'h0, 32'h1000, 512, 0, 'h11, -1, 0);
    submit(32'h0, 32'h1000, 512, 0, 'h12, -1, 0);
    repeat (6) @(posedge clk);
    #1;
    nrst = 0;
    @(negedge clk);
    check("mid_rst_start", eng_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", job_ready, 1);
    @(posedge clk); #1;
    nrst = 1;
    eng_hold = 0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", job_ready, 1);
`ifdef SCAN_WDOG_EN
    hold_run = eng_runs + 2;
    submit(32'h0, 32'h300000, 768, 0, 'h77, 1, 0);
    submit(32'h400000, 32'h100000, 1024, 1, 'h78, -1, 0);
    wait_idle();
    hold_run = 0;
`endif
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 3);
      b = ($urandom_range(0, 9) == 0) ? (32'hFFC00000 | 32'($urandom_range(0, 32'h3FFFFF)))
                                      : 32'($urandom_range(0, 32'h0FFFFFFF));
      l = r == 0 ? 32'h0 : r == 1 ? 32'(CHUNK) * 32'($urandom_range(1, 3))
        : r == 2 ? 32'($urandom_range(1, 4 * CHUNK)) : 32'($urandom_range(1, 16));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      submit(b, l, $urandom_range(0, 9) < 8 ? dms[$urandom_range(0, 5)] : int'($urandom_range(0, 2047)),
             1'($urandom_range(0, 1)), i + 'h80, -1, 0);
    end
    wait_idle();
    check("end_busy", busy, 0);
    check("end_ready", job_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
